// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file write-back arbiter and its requesters.
package regfile_wb_arbiter_pkg;

  localparam int unsigned REGF_AW = 5;
  localparam int unsigned REGF_DW = 32;

  localparam logic [REGF_AW-1:0] REG_ZERO = '0;

  // Requester slot assignment on the shared write port
  localparam int unsigned REQ_ALU    = 0;
  localparam int unsigned REQ_LOAD   = 1;
  localparam int unsigned REQ_MULDIV = 2;

endpackage

// File: rtl/regfile_wb_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping modulo N.
module regfile_wb_arbiter_rr_pick #(
  parameter int unsigned N  = 3,
  parameter int unsigned PW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  always_comb begin : p_pick
    int unsigned c;
    c       = 0;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      c = (int'(i_ptr) + i) % N;
      if (!o_any && i_req[c]) begin
        o_any      = 1'b1;
        o_grant[c] = 1'b1;
        o_idx      = PW'(c);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter sharing the register-file write port; writes to r0 are dropped.
// Optional REGF_WB_FWD_EN adds same-cycle bypass outputs from the registered write stage.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 3,
  parameter int unsigned DW   = REGF_DW,
  parameter int unsigned AW   = REGF_AW,
  parameter int unsigned CNTW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_reg,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 hold,
  output logic                 wr_en,
  output logic [AW-1:0]        wreg,
  output logic [DW-1:0]        wdata,
  output logic [NREQ-1:0]      last_grant,
  output logic [CNTW-1:0]      r0_drop_cnt
`ifdef REGF_WB_FWD_EN
  ,
  output logic                 fwd_valid,
  output logic [AW-1:0]        fwd_reg,
  output logic [DW-1:0]        fwd_data
`endif
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   r_ptr;
  logic            r_wr_en;
  logic [AW-1:0]   r_wreg;
  logic [DW-1:0]   r_wdata;
  logic [NREQ-1:0] r_last_grant;
  logic [CNTW-1:0] r_drop_cnt;

  logic [NREQ-1:0] w_grant;
  logic [PW-1:0]   w_idx;
  logic [PW-1:0]   w_ptr_next;
  logic            w_any;
  logic            w_accept;
  logic [AW-1:0]   w_sel_reg;
  logic [DW-1:0]   w_sel_data;
  logic            w_sel_zero;

  regfile_wb_arbiter_rr_pick #(
    .N  (NREQ),
    .PW (PW)
  ) u_rr_pick (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Grants are suppressed during reset as well as during hold
  assign w_accept  = w_any & ~hold & rst;
  assign req_ready = w_accept ? w_grant : '0;

  always_comb begin
    w_sel_reg  = '0;
    w_sel_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_grant[k]) begin
        w_sel_reg  = req_reg[k*AW +: AW];
        w_sel_data = req_data[k*DW +: DW];
      end
    end
  end

  assign w_sel_zero = (w_sel_reg == AW'(REG_ZERO));
  assign w_ptr_next = (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + PW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr        <= '0;
      r_wr_en      <= 1'b0;
      r_wreg       <= '0;
      r_wdata      <= '0;
      r_last_grant <= '0;
      r_drop_cnt   <= '0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_accept) begin
        r_ptr        <= w_ptr_next;
        r_last_grant <= w_grant;
        r_wreg       <= w_sel_reg;
        r_wdata      <= w_sel_data;
        r_wr_en      <= ~w_sel_zero;
        if (w_sel_zero && (r_drop_cnt != '1)) begin
          r_drop_cnt <= r_drop_cnt + CNTW'(1);
        end
      end
    end
  end

  assign wr_en       = r_wr_en;
  assign wreg        = r_wreg;
  assign wdata       = r_wdata;
  assign last_grant  = r_last_grant;
  assign r0_drop_cnt = r_drop_cnt;

`ifdef REGF_WB_FWD_EN
  assign fwd_valid = r_wr_en;
  assign fwd_reg   = r_wreg;
  assign fwd_data  = r_wdata;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (NREQ=3, AW=5, DW=32, CNTW=8).
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  logic        clk;
  logic        rst;
  logic [2:0]  req_valid;
  logic [14:0] req_reg;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        hold;
  logic        wr_en;
  logic [4:0]  wreg;
  logic [31:0] wdata;
  logic [2:0]  last_grant;
  logic [7:0]  r0_drop_cnt;
`ifdef REGF_WB_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_reg;
  logic [31:0] fwd_data;
`endif

  int n_tests;
  int n_fail;

  regfile_wb_arbiter #(
    .NREQ (3),
    .DW   (32),
    .AW   (5),
    .CNTW (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_reg     (req_reg),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .hold        (hold),
    .wr_en       (wr_en),
    .wreg        (wreg),
    .wdata       (wdata),
    .last_grant  (last_grant),
    .r0_drop_cnt (r0_drop_cnt)
`ifdef REGF_WB_FWD_EN
    ,
    .fwd_valid   (fwd_valid),
    .fwd_reg     (fwd_reg),
    .fwd_data    (fwd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit found;
    int wait_cyc;
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b0;
    hold      = 1'b0;
    req_valid = '0;
    req_reg   = '0;
    req_data  = '0;

    // Reset state
    step();
    step();
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_wreg", 64'(wreg), 64'd0);
    check("rst_last_grant", 64'(last_grant), 64'd0);
    check("rst_drop_cnt", 64'(r0_drop_cnt), 64'd0);

    // First write after release
    rst = 1'b1;
    req_valid = 3'b001;
    req_reg[REQ_ALU*5 +: 5]   = 5'd5;
    req_data[REQ_ALU*32 +: 32] = 32'h1234;
    #1;
    check("rel_ready", 64'(req_ready), 64'b001);
    step();
    check("rel_wr_en", 64'(wr_en), 64'd1);
    check("rel_wreg", 64'(wreg), 64'd5);
    check("rel_wdata", 64'(wdata), 64'h1234);
    check("rel_last_grant", 64'(last_grant), 64'b001);
    req_valid = '0;
    step();
    check("idle_wr_en", 64'(wr_en), 64'd0);
    check("idle_wreg_hold", 64'(wreg), 64'd5);

    // Asynchronous reset mid-traffic (ptr=1 -> requester 1 accepted first)
    req_valid = 3'b111;
    req_reg   = {5'd3, 5'd2, 5'd1};
    req_data  = {32'hC, 32'hB, 32'hA};
    step();
    check("mid_wreg", 64'(wreg), 64'd2);
    rst = 1'b0;
    #1;
    check("async_wr_en", 64'(wr_en), 64'd0);
    check("async_wreg", 64'(wreg), 64'd0);
    check("async_wdata", 64'(wdata), 64'd0);
    check("async_last_grant", 64'(last_grant), 64'd0);
    check("async_ready", 64'(req_ready), 64'd0);
    step();
    rst = 1'b1;
    #1;

    // Round robin from ptr=0
    check("rr_ready0", 64'(req_ready), 64'b001);
    step();
    check("rr_g0", 64'({wr_en, wreg, last_grant}), 64'({1'b1, 5'd1, 3'b001}));
    step();
    check("rr_g1", 64'({wr_en, wreg, last_grant}), 64'({1'b1, 5'd2, 3'b010}));
    step();
    check("rr_g2", 64'({wr_en, wreg, last_grant}), 64'({1'b1, 5'd3, 3'b100}));
    step();
    check("rr_g3", 64'({wr_en, wreg, last_grant}), 64'({1'b1, 5'd1, 3'b001}));
    check("rr_wdata", 64'(wdata), 64'hA);

    // Hold: registered write survives, then no grants for 4 cycles
    hold = 1'b1;
    #1;
    check("hold_ready", 64'(req_ready), 64'd0);
    check("hold_keeps_wr_en", 64'(wr_en), 64'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("hold_wr_en_%0d", i), 64'({wr_en, req_ready}), 64'd0);
    end
    check("hold_wreg_hold", 64'(wreg), 64'd1);
    hold = 1'b0;
    #1;
    check("hold_resume_ready", 64'(req_ready), 64'b010);
    step();
    check("hold_resume_wreg", 64'(wreg), 64'd2);

    // Writes to register 0 are dropped and counted
    req_valid = 3'b010;
    req_reg[REQ_LOAD*5 +: 5]    = 5'd0;
    req_data[REQ_LOAD*32 +: 32] = 32'hDEAD;
    #1;
    check("r0_ready", 64'(req_ready), 64'b010);
    step();
    check("r0_wr_en", 64'(wr_en), 64'd0);
    check("r0_wdata", 64'(wdata), 64'hDEAD);
    check("r0_cnt1", 64'(r0_drop_cnt), 64'd1);
    check("r0_last_grant", 64'(last_grant), 64'b010);
    for (int i = 1; i < 300; i++) step();
    check("r0_cnt_sat", 64'(r0_drop_cnt), 64'd255);
    check("r0_wr_en_sat", 64'(wr_en), 64'd0);

    // Fairness: ptr=2 now; one cycle with only 0,1 valid moves ptr to 1
    req_valid = 3'b011;
    req_reg   = {5'd31, 5'd2, 5'd1};
    req_data  = {32'h5555_AAAA, 32'hB, 32'hA};
    step();
    check("fair_pre_wreg", 64'(wreg), 64'd1);
    req_valid = 3'b111;
    found     = 1'b0;
    wait_cyc  = 0;
    for (int i = 1; i <= 3; i++) begin
      step();
      if (!found && wr_en && wreg == 5'd31) begin
        found    = 1'b1;
        wait_cyc = i;
      end
    end
    check("fair_found", 64'(found), 64'd1);
    check("fair_cycles", 64'(wait_cyc), 64'd2);

    // Bypass / write-stage visibility
    req_valid = 3'b100;
    req_reg[REQ_MULDIV*5 +: 5]    = 5'd7;
    req_data[REQ_MULDIV*32 +: 32] = 32'hCAFE;
    step();
`ifdef REGF_WB_FWD_EN
    check("fwd_write", 64'({fwd_valid, fwd_reg, fwd_data}), 64'({1'b1, 5'd7, 32'hCAFE}));
`else
    check("wb_write", 64'({wr_en, wreg, wdata}), 64'({1'b1, 5'd7, 32'hCAFE}));
`endif
    req_reg[REQ_MULDIV*5 +: 5] = 5'd0;
    step();
`ifdef REGF_WB_FWD_EN
    check("fwd_r0", 64'(fwd_valid), 64'd0);
`else
    check("wb_r0", 64'(wr_en), 64'd0);
`endif
    req_valid = '0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter for the MIPS 32×32 register file: shares its single write port (wr_en/wreg/wdata) among NREQ write-back requesters (ALU, load unit, multiply/divide unit). Round-robin grant with valid/ready handshake, one registered output stage feeding the register file. Writes to register 0 are accepted and discarded. Sits between the execute/memory stages and the register file write port.

## Interface
- NREQ, 3, number of write-back requesters (2..8)
- DW, 32, data width
- AW, 5, register address width
- CNTW, 8, width of the discarded-write counter

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- req_valid  in  NREQ  requester i has a write pending
- req_reg  in  NREQ*AW  destination register, requester i at bits [i*AW +: AW]
- req_data  in  NREQ*DW  write data, requester i at bits [i*DW +: DW]
- req_ready  out  NREQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
- hold  in  1  freeze arbitration (no grants while 1)
- wr_en  out  1  register-file write enable (registered)
- wreg  out  AW  register-file write address (registered)
- wdata  out  DW  register-file write data (registered)
- last_grant  out  NREQ  one-hot of the most recent accepted requester (registered)
- r0_drop_cnt  out  CNTW  count of discarded writes to register 0, saturating

## Operation
- Round-robin pointer ptr (0..NREQ-1) marks highest-priority requester; search ptr, ptr+1, … wrapping modulo NREQ; first valid requester wins.
- req_ready is combinational: one-hot winner when hold=0, all zero when hold=1 or no req_valid.
- On accept of requester k: ptr <= (k+1) mod NREQ; last_grant <= one-hot(k); wreg <= req_reg[k]; wdata <= req_data[k]; wr_en <= (req_reg[k] != 0).
- Accept with req_reg[k]==0: wr_en <= 0, wreg/wdata still loaded, r0_drop_cnt += 1, saturating at 2^CNTW-1.
- No accept in a cycle: wr_en <= 0; wreg, wdata, last_grant, ptr hold.
- Requester rule: once req_valid[i] is 1, req_reg/req_data stay stable until accepted; arbiter never drops a non-zero-register request.
- Requests to the same register from two requesters in one cycle: only winner accepted; loser is written in a later cycle (program order is the requesters' responsibility).
- Reset (any time, asynchronous): ptr=0, wr_en=0, wreg=0, wdata=0, last_grant=0, r0_drop_cnt=0, req_ready=0 while rst=0. An in-flight write registered but not yet consumed is lost.

## Timing
- Latency: accept in cycle N → wr_en/wreg/wdata valid in cycle N+1 (one cycle).
- Throughput: one write per cycle while any requester valid and hold=0.
- Fairness: a continuously valid requester is granted within NREQ cycles of hold=0.
- hold rising in cycle N: no accept in N; wr_en=0 in N+1. hold does not affect an output already registered.
- Reset release: first accept possible in the first rising edge with rst=1.

## Configuration
- REGF_WB_FWD_EN defined: adds outputs fwd_valid (1), fwd_reg (AW), fwd_data (DW) driven from the registered write stage: fwd_valid=wr_en, fwd_reg=wreg, fwd_data=wdata, so readers bypass the value in the same cycle it is written. Reset value of fwd_valid 0.
- Not defined: ports absent; readers see the value only through the register file.

## Structure
- Shared package: AW/DW constants, REG_ZERO address constant, requester index constants (REQ_ALU=0, REQ_LOAD=1, REQ_MULDIV=2).
- One sub-module: rr_pick (combinational round-robin priority picker: req vector + ptr → one-hot grant and index), reusable by other arbiters.

## Test plan
- Reset: rst=0 mid-traffic → all outputs 0 immediately; after release, req_valid=3'b001, reg=5, data=0x1234 → next cycle wr_en=1, wreg=5, wdata=0x1234, last_grant=3'b001.
- Round-robin: all three valid continuously (regs 1,2,3) from ptr=0 → grants 001,010,100,001 in consecutive cycles; wr_en=1 every cycle after first.
- Register 0: req_valid=3'b010, reg=0, data=0xDEAD → req_ready=3'b010, next cycle wr_en=0, r0_drop_cnt=1; 300 such writes with CNTW=8 → r0_drop_cnt=255.
- Hold: hold=1 for 4 cycles with all valid → req_ready=0, wr_en=0; hold=0 → grant resumes at stored ptr.
- Fairness/stability: requester 2 valid with reg=31 while 0 and 1 continuously valid → granted within 3 cycles, data unchanged on wdata.
- REGF_WB_FWD_EN: accept reg=7, data=0xCAFE → next cycle fwd_valid=1, fwd_reg=7, fwd_data=0xCAFE; reg=0 accept → fwd_valid=0.
